adc_sar_ctrl: RTL and testbench

Clocked, parametrised successor to the asynchronous sequence-driven ADC digital block. It generates sampling and comparator clocks internally from one system clock and runs an N_BITS successive-approximation search over the P/N capacitive DACs. It returns each conversion word over a valid/ready handshake and supports single-shot and continuous conversion. It sits between the ADC analog macros (sampling switches, comparator, capacitor drivers) and the chip's readout logic.

---
 rtl/adc_pkg.sv | 5 +
 rtl/adc_sar_ctrl_if.sv | 9 +
 rtl/adc_sar_datapath.sv | 45 ++++
 rtl/adc_sar_ctrl.sv | 117 +++++++++++
 tb/tb_adc_sar_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// adc_pkg: FSM states and DAC switching modes shared by the SAR controller
package adc_pkg;
  typedef enum logic [2:0] {IDLE, INIT, SAMP, COMP, SETTLE, DONE} state_t;
  typedef enum logic {DAC_MONO = 1'b0, DAC_SPLIT = 1'b1} dac_mode_t;
endpackage

// File: rtl/adc_sar_ctrl_if.sv
// adc_sar_ctrl_if: conversion-word stream towards readout, with overrun flag
interface adc_sar_ctrl_if #(parameter int N_BITS = 16);
  logic [N_BITS-1:0] result;
  logic result_valid;
  logic result_ready;
  logic overrun;
  modport master (output result, result_valid, overrun, input result_ready);
  modport slave (input result, result_valid, overrun, output result_ready);
endinterface

// File: rtl/adc_sar_datapath.sv
// adc_sar_datapath: DAC state registers, decision-driven switching and result bit capture
module adc_sar_datapath import adc_pkg::*; #(
  parameter int N_BITS = 16,
  parameter int KW = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              init,
  input  logic              capture,
  input  logic [KW-1:0]     k,
  input  logic              dac_mode,
  input  logic              comp_out_p,
  input  logic              comp_out_n,
  input  logic [N_BITS-1:0] dac_astate_p,
  input  logic [N_BITS-1:0] dac_bstate_p,
  input  logic [N_BITS-1:0] dac_astate_n,
  input  logic [N_BITS-1:0] dac_bstate_n,
  output logic [N_BITS-1:0] dac_p,
  output logic [N_BITS-1:0] dac_n,
  output logic [N_BITS-1:0] word,
  output logic              comp_err
);
  logic tie, d, split;
  assign tie = comp_out_p == comp_out_n;
  assign d = comp_out_p & ~tie;
  assign split = dac_mode == DAC_SPLIT;
  // INIT loads the initial DAC states; each COMP cycle commits one decision for bit k
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      dac_p <= '0;
      dac_n <= '0;
      word <= '0;
      comp_err <= 1'b0;
    end else if (init) begin
      dac_p <= dac_astate_p;
      dac_n <= dac_astate_n;
      word <= '0;
      comp_err <= 1'b0;
    end else if (capture) begin
      word[k] <= d;
      comp_err <= comp_err | tie;
      dac_p[k] <= d ? dac_bstate_p[k] : (split ? dac_astate_p[k] : dac_p[k]);
      dac_n[k] <= d ? (split ? dac_astate_n[k] : dac_n[k]) : dac_bstate_n[k];
    end
endmodule

// File: rtl/adc_sar_ctrl.sv
// adc_sar_ctrl: clocked SAR ADC sequencer with internal sample/compare clocks and result handshake
module adc_sar_ctrl import adc_pkg::*; #(
  parameter int N_BITS = 16,
  parameter int SAMP_W = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic              cont,
  input  logic [SAMP_W-1:0] samp_len,
  input  logic              en_samp_p,
  input  logic              en_samp_n,
  input  logic              en_comp,
  input  logic              dac_mode,
  input  logic              dac_diffcaps,
  input  logic [N_BITS-1:0] dac_astate_p,
  input  logic [N_BITS-1:0] dac_bstate_p,
  input  logic [N_BITS-1:0] dac_astate_n,
  input  logic [N_BITS-1:0] dac_bstate_n,
  input  logic              comp_out_p,
  input  logic              comp_out_n,
  output logic              clk_samp_p,
  output logic              clk_samp_p_b,
  output logic              clk_samp_n,
  output logic              clk_samp_n_b,
  output logic              clk_comp,
  output logic [N_BITS-1:0] dac_state_p_main,
  output logic [N_BITS-1:0] dac_state_p_diff,
  output logic [N_BITS-1:0] dac_state_n_main,
  output logic [N_BITS-1:0] dac_state_n_diff,
  output logic              dac_invert_p_main,
  output logic              dac_invert_n_main,
  output logic              dac_invert_p_diff,
  output logic              dac_invert_n_diff,
  output logic              busy,
  output logic              comp_err,
  adc_sar_ctrl_if.master    rd
);
  localparam int KW = N_BITS > 1 ? $clog2(N_BITS) : 1;
  state_t state, nxt;
  logic [KW-1:0] k;
  logic [SAMP_W-1:0] cnt;
  logic [N_BITS-1:0] word, dac_p, dac_n;
  logic drop;
  assign drop = rd.result_valid & ~rd.result_ready;
  assign dac_state_p_main = dac_p;
  assign dac_state_p_diff = dac_p;
  assign dac_state_n_main = dac_n;
  assign dac_state_n_diff = dac_n;
  assign dac_invert_p_main = 1'b0;
  assign dac_invert_n_main = 1'b0;
  assign dac_invert_p_diff = dac_diffcaps;
  assign dac_invert_n_diff = dac_diffcaps;
  // next-state decode; the clock outputs are registered from it so they line up with their phases
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (start | cont) ? INIT : IDLE;
      INIT:    nxt = SAMP;
      SAMP:    nxt = (cnt == samp_len) ? COMP : SAMP;
      COMP:    nxt = SETTLE;
      SETTLE:  nxt = (k == '0) ? DONE : COMP;
      DONE:    nxt = cont ? INIT : IDLE;
      default: nxt = IDLE;
    endcase
  end
  // sequencer state, counters, glitch-free clock outputs and result handshake
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      state <= IDLE;
      k <= '0;
      cnt <= '0;
      clk_samp_p <= 1'b0;
      clk_samp_p_b <= 1'b1;
      clk_samp_n <= 1'b0;
      clk_samp_n_b <= 1'b1;
      clk_comp <= 1'b0;
      busy <= 1'b0;
      rd.result <= '0;
      rd.result_valid <= 1'b0;
      rd.overrun <= 1'b0;
    end else begin
      state <= nxt;
      k <= state == INIT ? KW'(N_BITS - 1) : state == SETTLE ? k - 1'b1 : k;
      cnt <= state == SAMP ? cnt + 1'b1 : '0;
      clk_samp_p <= nxt == SAMP && en_samp_p;
      clk_samp_p_b <= !(nxt == SAMP && en_samp_p);
      clk_samp_n <= nxt == SAMP && en_samp_n;
      clk_samp_n_b <= !(nxt == SAMP && en_samp_n);
      clk_comp <= nxt == COMP && en_comp;
      busy <= nxt != IDLE;
      rd.overrun <= state == DONE && drop;
      if (state == DONE && !drop) begin
        rd.result <= word;
        rd.result_valid <= 1'b1;
      end else if (rd.result_ready)
        rd.result_valid <= 1'b0;
    end
  adc_sar_datapath #(.N_BITS(N_BITS), .KW(KW)) u_dp (
    .clk(clk),
    .rst_b(rst_b),
    .init(state == INIT),
    .capture(state == COMP),
    .k(k),
    .dac_mode(dac_mode),
    .comp_out_p(comp_out_p),
    .comp_out_n(comp_out_n),
    .dac_astate_p(dac_astate_p),
    .dac_bstate_p(dac_bstate_p),
    .dac_astate_n(dac_astate_n),
    .dac_bstate_n(dac_bstate_n),
    .dac_p(dac_p),
    .dac_n(dac_n),
    .word(word),
    .comp_err(comp_err)
  );
endmodule

// File: tb/tb_adc_sar_ctrl.sv
// tb_adc_sar_ctrl: directed/random conversions checked against a timeline-based reference model
module tb_adc_sar_ctrl;
  localparam int N = 16;
  logic clk = 0, rst_b = 0, start = 0, cont = 0;
  logic [3:0] samp_len = 4'd3;
  logic en_samp_p = 1, en_samp_n = 1, en_comp = 1, dac_mode = 0, dac_diffcaps = 0;
  logic [N-1:0] ap = '0, bp = '1, an = '0, bn = '1;
  logic cop = 0, con = 0;
  logic sp, spb, sn, snb, cc, ipm, inm, ipd, ind, busy, comp_err;
  logic [N-1:0] pm, pd, nm, nd;
  int errors = 0, checks = 0;
  logic m_rv = 0, m_ovr = 0, m_cerr = 0;
  logic [N-1:0] m_res = '0, m_p = '0, m_n = '0;

  adc_sar_ctrl_if #(.N_BITS(N)) bus ();

  adc_sar_ctrl #(.N_BITS(N), .SAMP_W(4)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .cont(cont), .samp_len(samp_len),
    .en_samp_p(en_samp_p), .en_samp_n(en_samp_n), .en_comp(en_comp),
    .dac_mode(dac_mode), .dac_diffcaps(dac_diffcaps),
    .dac_astate_p(ap), .dac_bstate_p(bp), .dac_astate_n(an), .dac_bstate_n(bn),
    .comp_out_p(cop), .comp_out_n(con),
    .clk_samp_p(sp), .clk_samp_p_b(spb), .clk_samp_n(sn), .clk_samp_n_b(snb), .clk_comp(cc),
    .dac_state_p_main(pm), .dac_state_p_diff(pd), .dac_state_n_main(nm), .dac_state_n_diff(nd),
    .dac_invert_p_main(ipm), .dac_invert_n_main(inm),
    .dac_invert_p_diff(ipd), .dac_invert_n_diff(ind),
    .busy(busy), .comp_err(comp_err), .rd(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // phase codes: 0 idle, 1 init, 2 sample, 3 compare, 4 settle, 5 done
  function automatic int phase_of(int c, int sl);
    if (c == 1) return 1;
    if (c <= sl + 2) return 2;
    if (c <= sl + 2 + 2 * N) return ((c - sl - 3) % 2 == 0) ? 3 : 4;
    return 5;
  endfunction

  task automatic check_cycle(input int ph, input string tag);
    chk({tag, "/ctl"}, {busy, sp, spb, sn, snb, cc, ipm, inm, ipd, ind},
        {ph != 0, ph == 2 && en_samp_p, !(ph == 2 && en_samp_p), ph == 2 && en_samp_n,
         !(ph == 2 && en_samp_n), ph == 3 && en_comp, 1'b0, 1'b0, dac_diffcaps, dac_diffcaps});
    chk({tag, "/dac_p"}, {pm, pd}, {m_p, m_p});
    chk({tag, "/dac_n"}, {nm, nd}, {m_n, m_n});
    chk({tag, "/result"}, {bus.result_valid, bus.result, bus.overrun}, {m_rv, m_res, m_ovr});
    chk({tag, "/comp_err"}, comp_err, m_cerr);
  endtask

  task automatic handshake_edge(input bit done, input logic [N-1:0] w);
    if (done && m_rv && !bus.result_ready) m_ovr = 1;
    else if (done) begin
      m_res = w;
      m_rv = 1;
      m_ovr = 0;
    end else begin
      m_ovr = 0;
      if (bus.result_ready) m_rv = 0;
    end
  endtask

  task automatic reset_model();
    m_rv = 0; m_ovr = 0; m_cerr = 0; m_res = '0; m_p = '0; m_n = '0;
  endtask

  task automatic idle(input int n, input logic rdy, input string tag);
    repeat (n) begin
      @(negedge clk);
      check_cycle(0, tag);
      bus.result_ready = rdy;
      {cop, con} = 2'($urandom);
      handshake_edge(0, '0);
    end
  endtask

  // one conversion; entered at the negedge just before the edge that enters INIT
  task automatic conv(input logic [N-1:0] code, input int err, input bit use_start,
                      input int rst_k, input bit ready_done, input bit drop_cont, input string tag);
    int p, ns, nc;
    logic [N-1:0] dw, dm;
    p = int'(samp_len) + 2 * N + 3;
    dw = code;
    if (err >= 0) dw[err] = 1'b0;
    ns = 0;
    nc = 0;
    start = use_start;
    for (int c = 1; c <= p; c++) begin
      int ph, kb;
      @(negedge clk);
      start = (c == 10);
      ph = phase_of(c, int'(samp_len));
      kb = N - 1 - (c - int'(samp_len) - 3) / 2;
      check_cycle(ph, tag);
      ns += int'(sp);
      nc += int'(cc);
      if (ph == 3 && kb == rst_k) begin
        start = 0;
        rst_b = 0;
        #1;
        reset_model();
        check_cycle(0, {tag, "/async_rst"});
        return;
      end
      if (ph == 5 && ready_done) bus.result_ready = 1;
      if (c == 5 && drop_cont) cont = 0;
      {cop, con} = ph == 3 ? (kb == err ? 2'b11 : {code[kb], ~code[kb]}) : 2'($urandom);
      handshake_edge(ph == 5, dw);
      if (ph == 1) begin
        m_p = ap;
        m_n = an;
        m_cerr = 0;
      end
      if (ph == 3) begin
        dm = {N{1'b1}} << kb;
        m_p = (dm & ((dw & bp) | (~dw & ap))) | (~dm & ap);
        m_n = (dm & ((dw & an) | (~dw & bn))) | (~dm & an);
        if (kb == err) m_cerr = 1;
      end
    end
    chk({tag, "/samp_cycles"}, ns, en_samp_p ? int'(samp_len) + 1 : 0);
    chk({tag, "/comp_pulses"}, nc, en_comp ? N : 0);
  endtask

  initial begin
    bus.result_ready = 0;
    repeat (2) @(negedge clk);
    check_cycle(0, "reset");
    rst_b = 1;
    idle(2, 0, "idle0");
    conv(16'hA5C3, -1, 1, -1, 0, 0, "mono");
    idle(3, 0, "mono_hold");
    idle(3, 1, "mono_read");
    dac_mode = 1;
    ap = N'($urandom); bp = N'($urandom); an = N'($urandom); bn = N'($urandom);
    conv(N'($urandom), -1, 1, -1, 0, 0, "split");
    idle(2, 1, "split_idle");
    conv(16'hA5C3, -1, 1, -1, 0, 0, "split_a5c3");
    idle(2, 0, "cont_pre");
    dac_mode = 0; ap = '0; bp = '1; an = '0; bn = '1;
    cont = 1;
    conv(N'($urandom), -1, 0, -1, 0, 0, "cont1");
    conv(N'($urandom), -1, 0, -1, 0, 0, "cont2_ovr");
    conv(N'($urandom), -1, 0, -1, 0, 0, "cont3_ovr");
    conv(N'($urandom), -1, 0, -1, 1, 0, "cont4_ready");
    conv(N'($urandom), -1, 0, -1, 0, 1, "cont5_drop");
    idle(3, 1, "cont_end");
    conv(16'hFFFF, 7, 1, -1, 0, 0, "comp_err");
    idle(2, 1, "cerr_idle");
    conv(16'h0081, -1, 1, -1, 0, 0, "cerr_clear");
    idle(1, 1, "pre_rst");
    conv(16'h1234, -1, 1, 9, 0, 0, "rst_bit9");
    idle(2, 1, "rst_hold");
    rst_b = 1;
    idle(1, 1, "rst_rel");
    conv(16'h5A5A, -1, 1, -1, 0, 0, "after_rst");
    idle(2, 1, "after_rst_idle");
    en_samp_n = 0; en_comp = 0; dac_diffcaps = 1; samp_len = 4'd0;
    conv(N'($urandom), -1, 1, -1, 0, 0, "gated_sl0");
    idle(2, 1, "gated_idle");
    samp_len = 4'd15;
    conv(N'($urandom), -1, 1, -1, 0, 0, "gated_sl15");
    idle(3, 1, "final_idle");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
